// File: rtl/arb_pkg.sv
// Shared types and constants for the parametrised round-robin / fixed-priority arbiter.
package arb_pkg;

  // Arbiter FSM: no owner, or an owner currently holds the grant.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Arbitration policy, selected at runtime through the mode pin.
  typedef enum bit {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Width of the hold counter and its saturation value.
  localparam int              HOLD_W   = 8;
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotating-priority picker: returns the first candidate at or
// after start_ptr (wrapping), where candidates are req bits not set in mask.
// A start_ptr of 0 gives plain lowest-index-first priority.
module arb_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start_ptr,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  logic [N-1:0] cand;

  assign cand = req & ~mask;

  // Scan from the farthest offset down to the start so the nearest candidate wins.
  always_comb begin
    int base;
    int idx;
    found  = 1'b0;
    winner = '0;
    base   = (int'(start_ptr) < N) ? int'(start_ptr) : 0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = base + k;
      if (idx >= N) idx = idx - N;
      if (cand[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/arb_rr_param.sv
// N-requester arbiter with runtime fixed-priority / round-robin selection,
// registered one-hot grant, and an optional hold limit that forces rotation
// when other requesters are waiting. state and rr_ptr are exposed for debug.
module arb_rr_param
  import arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              mode,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic              gnt_valid,
  output logic [ID_W-1:0]   gnt_id,
  output logic [HOLD_W-1:0] hold_cnt,
  output arb_state_e        state,
  output logic [ID_W-1:0]   rr_ptr
);

  // Handshake: req is a level; a requester owns the resource exactly while its
  // gnt bit is high, and keeps it by holding req high. Dropping req releases
  // the grant at the next edge; there is no separate acknowledge.

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  arb_state_e        next_state;
  logic              owner_req;
  logic              limit_hit;
  logic              force_rot;
  logic [N_REQ-1:0]  pick_mask;
  logic [ID_W-1:0]   start_ptr;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic              grant_new;
  logic              keep_restart;
  logic [N_REQ-1:0]  gnt_d;
  logic [ID_W-1:0]   gnt_id_d;
  logic [HOLD_W-1:0] hold_d;
  logic [ID_W-1:0]   ptr_d;

  assign owner_req = req[gnt_id];
  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
  assign force_rot = (state == GRANT) && owner_req && limit_hit;
  // When rotation is forced the current owner must not win again.
  assign pick_mask = force_rot ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
  assign start_ptr = (arb_mode_e'(mode) == ARB_RR) ? rr_ptr : '0;

  arb_rr_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req       (req),
    .mask      (pick_mask),
    .start_ptr (start_ptr),
    .found     (found),
    .winner    (winner)
  );

  // State and grant registers; reset clears everything asynchronously.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= next_state;
      gnt      <= gnt_d;
      gnt_id   <= gnt_id_d;
      hold_cnt <= hold_d;
      rr_ptr   <= ptr_d;
    end
  end

  // Arbitration decision: start a new grant, keep the owner, or go idle.
  always_comb begin
    next_state   = state;
    grant_new    = 1'b0;
    keep_restart = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          next_state = GRANT;
          grant_new  = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Release hands over on the same edge when someone else is waiting.
          if (found) grant_new  = 1'b1;
          else       next_state = IDLE;
        end else if (limit_hit) begin
          if (found) grant_new    = 1'b1;
          else       keep_restart = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Next values for the registered grant, owner id, hold counter and pointer.
  always_comb begin
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    hold_d   = hold_cnt;
    ptr_d    = rr_ptr;
    if (grant_new) begin
      gnt_d         = '0;
      gnt_d[winner] = 1'b1;
      gnt_id_d      = winner;
      hold_d        = HOLD_W'(1);
      ptr_d         = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end else if (next_state == IDLE) begin
      gnt_d    = '0;
      gnt_id_d = '0;
      hold_d   = '0;
    end else if (keep_restart) begin
      hold_d = HOLD_W'(1);
    end else begin
      hold_d = (hold_cnt == HOLD_SAT) ? HOLD_SAT : hold_cnt + 1'b1;
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: tb/tb_arb_rr_param.sv
// Bench for arb_rr_param: two instances (unlimited hold and MAX_HOLD=2) share
// one stimulus stream; a behavioural model checks both every cycle and
// directed literal expectations pin the model.
module tb_arb_rr_param;
  import arb_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset / stimulus signals ----------------
  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       mode  = 1'b0;
  logic [3:0] req   = 4'b0000;

  always #5 clock = ~clock;

  logic [3:0] a_gnt, b_gnt;
  logic       a_valid, b_valid;
  logic [1:0] a_id, b_id, a_ptr, b_ptr;
  logic [7:0] a_hold, b_hold;
  arb_state_e a_state, b_state;

  arb_rr_param #(.N_REQ(N), .MAX_HOLD(0)) dut_a (
    .clock(clock), .rst(rst), .mode(mode), .req(req),
    .gnt(a_gnt), .gnt_valid(a_valid), .gnt_id(a_id), .hold_cnt(a_hold),
    .state(a_state), .rr_ptr(a_ptr)
  );

  arb_rr_param #(.N_REQ(N), .MAX_HOLD(2)) dut_b (
    .clock(clock), .rst(rst), .mode(mode), .req(req),
    .gnt(b_gnt), .gnt_valid(b_valid), .gnt_id(b_id), .hold_cnt(b_hold),
    .state(b_state), .rr_ptr(b_ptr)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: owner index (-1 = none), cycles held, round-robin start.
  int         m_owner [2];
  int         m_held  [2];
  int         m_ptr   [2];
  int         m_limit [2] = '{0, 2};
  logic [3:0] m_req_edge;

  function automatic int pick(input logic [3:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_owner[d] <= -1;
        m_held[d]  <= 0;
        m_ptr[d]   <= 0;
      end
      m_req_edge <= 4'b0000;
    end else begin
      m_req_edge <= req;
      for (int d = 0; d < 2; d++) begin
        int o, h, p, w, start;
        o     = m_owner[d];
        h     = m_held[d];
        p     = m_ptr[d];
        start = mode ? p : 0;
        if (o < 0 || !req[o]) begin
          w = pick(req, start, -1);
          if (w >= 0) begin o = w; h = 1; p = (w + 1) % N; end
          else begin o = -1; h = 0; end
        end else if (m_limit[d] != 0 && h == m_limit[d]) begin
          w = pick(req, start, o);
          if (w >= 0) begin o = w; h = 1; p = (w + 1) % N; end
          else h = 1;
        end else begin
          h = (h < 255) ? h + 1 : 255;
        end
        m_owner[d] <= o;
        m_held[d]  <= h;
        m_ptr[d]   <= p;
      end
    end
  end

  task automatic compare_dut(input int d, input string tag,
                             input logic [3:0] gnt, input logic valid,
                             input logic [1:0] id, input logic [7:0] hold,
                             input arb_state_e st, input logic [1:0] ptr);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0000;
    if (m_owner[d] >= 0) exp_gnt[m_owner[d]] = 1'b1;
    check({tag, "_gnt"},   32'(gnt),   32'(exp_gnt));
    check({tag, "_valid"}, 32'(valid), 32'(m_owner[d] >= 0));
    check({tag, "_id"},    32'(id),    (m_owner[d] >= 0) ? 32'(m_owner[d]) : 32'd0);
    check({tag, "_hold"},  32'(hold),  32'(m_held[d]));
    check({tag, "_state"}, 32'(st),    (m_owner[d] >= 0) ? 32'(GRANT) : 32'(IDLE));
    check({tag, "_ptr"},   32'(ptr),   32'(m_ptr[d]));
    check({tag, "_onehot0"}, 32'($onehot0(gnt)), 32'd1);
    check({tag, "_gnt_had_req"}, 32'(gnt & ~m_req_edge), 32'd0);
    check({tag, "_valid_is_or"}, 32'(valid), 32'(|gnt));
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clock) begin
    compare_dut(0, "a", a_gnt, a_valid, a_id, a_hold, a_state, a_ptr);
    compare_dut(1, "b", b_gnt, b_valid, b_id, b_hold, b_state, b_ptr);
  end

  // ---------------- directed stimulus with literal expectations ----------------
  logic [3:0] t3_exp [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                              4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};

  initial begin
    // Reset held with every requester asking: nothing may be granted.
    #2 rst = 1'b0;
    req = 4'b1111;
    repeat (3) begin
      @(negedge clock);
      check("t1_rst_gnt_a",  32'(a_gnt),  32'd0);
      check("t1_rst_gnt_b",  32'(b_gnt),  32'd0);
      check("t1_rst_id_a",   32'(a_id),   32'd0);
      check("t1_rst_hold_b", 32'(b_hold), 32'd0);
    end
    rst = 1'b1;
    @(negedge clock);
    check("t1_first_gnt_a",  32'(a_gnt),  32'h1);
    check("t1_first_hold_a", 32'(a_hold), 32'd1);
    check("t1_first_gnt_b",  32'(b_gnt),  32'h1);
    req = 4'b0000;
    @(negedge clock);
    check("t1_idle_gnt_a", 32'(a_gnt), 32'd0);

    // Fixed priority, unlimited hold: owner 1 keeps it; hold_cnt saturates.
    mode = 1'b0;
    req  = 4'b1010;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      check("t2_hold_gnt_a", 32'(a_gnt), 32'h2);
    end
    check("t2_sat_hold_a", 32'(a_hold), 32'd255);
    req = 4'b1000;
    @(negedge clock);
    check("t2_handover_gnt_a",  32'(a_gnt),  32'h8);
    check("t2_handover_hold_a", 32'(a_hold), 32'd1);
    req = 4'b0000;
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;

    // Round-robin, all requesting: MAX_HOLD=2 rotates every two cycles.
    mode = 1'b1;
    req  = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t3_rr_gnt_b", 32'(b_gnt), 32'(t3_exp[i]));
      check("t3_rr_gnt_a", 32'(a_gnt), 32'h1);
    end

    // Single requester under a hold limit: keeps grant, counter restarts.
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("t4_solo_gnt_b",  32'(b_gnt),  32'h4);
      check("t4_solo_hold_b", 32'(b_hold), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("t4_solo_gnt_a",  32'(a_gnt),  32'h4);
    end

    // One-cycle pulse from requester 0 while 2 owns the grant is lost.
    @(negedge clock);
    check("t5_pre_hold_b", 32'(b_hold), 32'd1);
    req = 4'b0101;
    @(negedge clock);
    check("t5_pulse_gnt_b",  32'(b_gnt),  32'h4);
    check("t5_pulse_hold_b", 32'(b_hold), 32'd2);
    check("t5_pulse_gnt_a",  32'(a_gnt),  32'h4);
    req = 4'b0100;
    @(negedge clock);
    check("t5_after_gnt_b",  32'(b_gnt),  32'h4);
    check("t5_after_hold_b", 32'(b_hold), 32'd1);

    // Reset mid-grant clears outputs at once and rewinds the RR pointer.
    mode = 1'b0;
    req  = 4'b0010;
    @(negedge clock);
    check("t6_pre_gnt_a", 32'(a_gnt), 32'h2);
    check("t6_pre_gnt_b", 32'(b_gnt), 32'h2);
    #2 rst = 1'b0;
    #1;
    check("t6_async_gnt_a",   32'(a_gnt),   32'd0);
    check("t6_async_gnt_b",   32'(b_gnt),   32'd0);
    check("t6_async_valid_b", 32'(b_valid), 32'd0);
    check("t6_async_id_b",    32'(b_id),    32'd0);
    check("t6_async_hold_b",  32'(b_hold),  32'd0);
    check("t6_async_state_b", 32'(b_state), 32'(IDLE));
    @(negedge clock);
    check("t6_ptr_b", 32'(b_ptr), 32'd0);
    check("t6_ptr_a", 32'(a_ptr), 32'd0);
    rst  = 1'b1;
    mode = 1'b1;
    req  = 4'b1001;
    @(negedge clock);
    check("t6_rr_restart_gnt_b", 32'(b_gnt), 32'h1);
    check("t6_rr_restart_gnt_a", 32'(a_gnt), 32'h1);

    req = 4'b0000;
    repeat (3) @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
